// File: rtl/fib_pkg.sv
// Shared types and default widths for the iterative Fibonacci engine.
// Optional build macro FIB_OVERFLOW_EN (saturate and flag on carry out).
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam int FIB_N_WIDTH_DEF      = 5;
    localparam int FIB_RESULT_WIDTH_DEF = 21;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci addition t1+t0; with FIB_OVERFLOW_EN it also reports the carry
// and saturates the sum to all-ones, otherwise it wraps and has no carry port.
module fib_step
    import fib_pkg::*;
#(
    parameter int RESULT_WIDTH = FIB_RESULT_WIDTH_DEF
) (
    input  logic [RESULT_WIDTH-1:0] i_t0,
    input  logic [RESULT_WIDTH-1:0] i_t1,
`ifdef FIB_OVERFLOW_EN
    output logic                    o_carry,
`endif
    output logic [RESULT_WIDTH-1:0] o_sum
);

`ifdef FIB_OVERFLOW_EN
    logic [RESULT_WIDTH:0] w_full;

    assign w_full  = {1'b0, i_t1} + {1'b0, i_t0};
    assign o_carry = w_full[RESULT_WIDTH];
    assign o_sum   = o_carry ? '1 : w_full[RESULT_WIDTH-1:0];
`else
    assign o_sum   = i_t1 + i_t0;
`endif

endmodule

// File: rtl/fib_sequencer.sv
// Iterative Fibonacci engine: one addition per clock, done pulse and held result.
// Optional build macro FIB_OVERFLOW_EN enables saturation and the overflow flag.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int N_WIDTH      = FIB_N_WIDTH_DEF,
    parameter int RESULT_WIDTH = FIB_RESULT_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [N_WIDTH-1:0]      n_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [RESULT_WIDTH-1:0] result_o,
    output logic                    overflow_o
);

    fib_state_t              r_state;
    logic [RESULT_WIDTH-1:0] r_t0;
    logic [RESULT_WIDTH-1:0] r_t1;
    logic [N_WIDTH-1:0]      r_n;
    logic [RESULT_WIDTH-1:0] w_sum;
`ifdef FIB_OVERFLOW_EN
    logic                    w_carry;
    logic                    r_ovf;
`endif

    fib_step #(
        .RESULT_WIDTH(RESULT_WIDTH)
    ) u_step (
        .i_t0   (r_t0),
        .i_t1   (r_t1),
`ifdef FIB_OVERFLOW_EN
        .o_carry(w_carry),
`endif
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_t0    <= '0;
            r_t1    <= '0;
            r_n     <= '0;
`ifdef FIB_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_t0    <= '0;
                        r_t1    <= RESULT_WIDTH'(1);
                        r_n     <= n_i;
`ifdef FIB_OVERFLOW_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= OP;
                    end
                end
                OP: begin
                    if (r_n == '0) begin
                        r_t1    <= '0;
                        r_state <= DONE;
                    end else if (r_n == N_WIDTH'(1)) begin
                        r_state <= DONE;
`ifdef FIB_OVERFLOW_EN
                    end else if (w_carry) begin
                        // Carry out: w_sum is already saturated, stop early.
                        r_t1    <= w_sum;
                        r_ovf   <= 1'b1;
                        r_state <= DONE;
`endif
                    end else begin
                        r_t1 <= w_sum;
                        r_t0 <= r_t1;
                        r_n  <= r_n - N_WIDTH'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign done_o   = (r_state == DONE);
    assign result_o = r_t1;
`ifdef FIB_OVERFLOW_EN
    assign overflow_o = r_ovf;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: default-width and 8-bit instances, directed table,
// multi-cycle corner sequences and random operands against an arithmetic model.
module tb_fib_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_a, start_b;
    logic [4:0]  n_a, n_b;
    logic        ready_a, done_a, ovf_a;
    logic [20:0] res_a;
    logic        ready_b, done_b, ovf_b;
    logic [7:0]  res_b;

    bit          sel8;
    logic        s_ready, s_done, s_ovf;
    logic [20:0] s_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fib_sequencer u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_a), .n_i(n_a),
        .ready_o(ready_a), .done_o(done_a), .result_o(res_a), .overflow_o(ovf_a)
    );

    fib_sequencer #(.N_WIDTH(5), .RESULT_WIDTH(8)) u_dut8 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_b), .n_i(n_b),
        .ready_o(ready_b), .done_o(done_b), .result_o(res_b), .overflow_o(ovf_b)
    );

    assign s_ready = sel8 ? ready_b : ready_a;
    assign s_done  = sel8 ? done_b  : done_a;
    assign s_ovf   = sel8 ? ovf_b   : ovf_a;
    assign s_res   = sel8 ? {13'd0, res_b} : res_a;

    typedef struct {
        bit     w8;
        int     n;
        longint exp_res;
        bit     exp_ovf;
        int     exp_lat;
    } vec_t;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: exact fib(n) by plain iteration, then wrap or saturate to w bits.
    // lat is the number of edges from the start edge to the first done_o cycle.
    function automatic void ref_fib(input int n, input int w,
                                    output longint r, output bit ov, output int lat);
        longint f[0:40];
        longint cap;
        f[0] = 0;
        f[1] = 1;
        for (int k = 2; k <= 40; k++) f[k] = f[k-1] + f[k-2];
        cap = longint'(1) << w;
        ov  = 1'b0;
        lat = (n < 1 ? 1 : n) + 1;
        r   = f[n] % cap;
`ifdef FIB_OVERFLOW_EN
        if (f[n] >= cap) begin
            int m;
            m = 2;
            while (f[m] < cap) m++;
            r   = cap - 1;
            ov  = 1'b1;
            lat = m;
        end
`endif
    endfunction

    // Start one request from an idle, step-aligned point and collect its outcome.
    task automatic run_op(input bit w8, input int n, output longint res, output bit ovf,
                          output int lat, output bit rdy_low, output bit pulse_ok);
        sel8 = w8;
        if (w8) begin start_b = 1'b1; n_b = n[4:0]; end
        else    begin start_a = 1'b1; n_a = n[4:0]; end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        rdy_low = !s_ready;
        lat = 1;
        while (!s_done && lat < 100) begin
            step();
            lat++;
        end
        res = s_res;
        ovf = s_ovf;
        step();
        pulse_ok = !s_done && s_ready;
    endtask

    initial begin
        vec_t   vecs[7];
        longint res;
        bit     ovf, rdy_low, pulse_ok, saw_done;
        int     lat;
        longint e_res;
        bit     e_ovf;
        int     e_lat;

        vecs[0] = '{1'b0, 10, 55,      1'b0, 11};
        vecs[1] = '{1'b0, 0,  0,       1'b0, 2};
        vecs[2] = '{1'b0, 1,  1,       1'b0, 2};
        vecs[3] = '{1'b0, 31, 1346269, 1'b0, 32};
        vecs[4] = '{1'b1, 13, 233,     1'b0, 14};
`ifdef FIB_OVERFLOW_EN
        vecs[5] = '{1'b1, 14, 255,     1'b1, 14};
`else
        vecs[5] = '{1'b1, 14, 121,     1'b0, 15};
`endif
        vecs[6] = '{1'b1, 1,  1,       1'b0, 2};

        sel8 = 1'b0;
        start_a = 1'b0; start_b = 1'b0; n_a = '0; n_b = '0;
        reset_i = 1'b1;
        #3;
        check("reset_ready", ready_a, 1);
        check("reset_done", done_a, 0);
        check("reset_result", res_a, 0);
        check("reset_ovf", ovf_a, 0);
        check("reset_result8", res_b, 0);
        step();
        reset_i = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].w8, vecs[i].n, res, ovf, lat, rdy_low, pulse_ok);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_ready_low", i), rdy_low, 1);
            check($sformatf("vec%0d_one_pulse_ready", i), pulse_ok, 1);
        end

        // Starts during OP and during DONE are dropped; first IDLE cycle accepts.
        sel8 = 1'b0;
        start_a = 1'b1; n_a = 5'd10;
        step();
        start_a = 1'b0;
        check("ign_ready_low", ready_a, 0);
        step();
        step();
        start_a = 1'b1; n_a = 5'd3;
        step();
        start_a = 1'b0;
        repeat (6) step();
        check("ign_no_early_done", done_a, 0);
        step();
        check("ign_done_e11", done_a, 1);
        check("ign_result_e11", res_a, 55);
        start_a = 1'b1; n_a = 5'd3;
        step();
        start_a = 1'b0;
        check("ign_done_gone", done_a, 0);
        check("ign_ready_e12", ready_a, 1);
        check("ign_result_held", res_a, 55);
        start_a = 1'b1; n_a = 5'd4;
        step();
        start_a = 1'b0;
        check("accept_first_idle", ready_a, 0);
        lat = 1;
        while (!done_a && lat < 100) begin
            step();
            lat++;
        end
        check("accept_latency", lat, 5);
        check("accept_result", res_a, 3);
        step();

        // Asynchronous reset in the middle of an n=20 run.
        start_a = 1'b1; n_a = 5'd20;
        step();
        start_a = 1'b0;
        repeat (4) step();
        reset_i = 1'b1;
        #1;
        check("abort_ready", ready_a, 1);
        check("abort_done", done_a, 0);
        check("abort_result", res_a, 0);
        check("abort_ovf", ovf_a, 0);
        #2;
        reset_i = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done_a) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run_op(1'b0, 5, res, ovf, lat, rdy_low, pulse_ok);
        check("after_abort_result", res, 5);
        check("after_abort_latency", lat, 6);

        // Random operands on both widths against the reference model.
        for (int i = 0; i < 24; i++) begin
            bit w8;
            int n;
            w8 = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 31));
            ref_fib(n, w8 ? 8 : 21, e_res, e_ovf, e_lat);
            run_op(w8, n, res, ovf, lat, rdy_low, pulse_ok);
            check($sformatf("rnd%0d_w%0d_n%0d_result", i, w8 ? 8 : 21, n), res, e_res);
            check($sformatf("rnd%0d_n%0d_ovf", i, n), ovf, e_ovf);
            check($sformatf("rnd%0d_n%0d_latency", i, n), lat, e_lat);
            check($sformatf("rnd%0d_n%0d_pulse", i, n), pulse_ok, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
